// File: rtl/bsg_counter_set_down_max_val_p128_init_val_p0.sv
`default_nettype none
// ============================================================================
// bsg_counter_set_down_max_val_p128_init_val_p0 -- loadable saturating down-counter
//    with zero decode and sticky underflow flag.  Rev 1.0
// ============================================================================
module bsg_counter_set_down_max_val_p128_init_val_p0 #(
   parameter  int MAX_VAL_P  = 128,
   parameter  int INIT_VAL_P = 0,
   localparam int W          = $clog2(MAX_VAL_P + 1)
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         clear_i,
   input  logic         set_i,
   input  logic [W-1:0] val_i,
   input  logic         down_i,
   output logic [W-1:0] count_o,
   output logic         zero_o,
   output logic         underflow_o
);

   localparam logic [W-1:0] C_MAX  = W'(MAX_VAL_P);
   localparam logic [W-1:0] C_INIT = W'(INIT_VAL_P);

   if (INIT_VAL_P > MAX_VAL_P) begin : g_bad_init
      $error("init value exceeds max value");
   end

   logic [W-1:0] count_q, count_d;
   logic         uf_q, uf_d;
   logic [W-1:0] w_base;
   logic         w_base_zero;
   logic         w_uf_evt;

   // val_i only reaches the base mux under set_i, so an X on it stays out of state
   always_comb begin
      w_base = count_q;
      if (clear_i)
         w_base = '0;
      else if (set_i)
         w_base = (val_i > C_MAX) ? C_MAX : val_i;
   end

   assign w_base_zero = (w_base == '0);
   assign w_uf_evt    = down_i & w_base_zero;

   always_comb begin
      count_d = w_base - W'(down_i & ~w_base_zero);
      uf_d    = clear_i ? w_uf_evt : (uf_q | w_uf_evt);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= C_INIT;
         uf_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         uf_q    <= uf_d;
      end
   end

   assign count_o     = count_q;
   assign zero_o      = (count_q == '0);
   assign underflow_o = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_counter_set_down_max_val_p128_init_val_p0.sv
`default_nettype none
// ============================================================================
// tb_bsg_counter_set_down_max_val_p128_init_val_p0 -- scoreboard bench for the
//    set/down counter.  Rev 1.0
// ============================================================================
module tb_bsg_counter_set_down_max_val_p128_init_val_p0;

   localparam int MAX  = 128;
   localparam int INIT = 0;

   typedef struct packed {
      logic [7:0] cnt;
      logic       zero;
      logic       uf;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       set_i = 1'b0;
   logic [7:0] val_i = '0;
   logic       down_i = 1'b0;
   logic [7:0] count_o;
   logic       zero_o;
   logic       underflow_o;

   int   errors = 0;
   int   checks = 0;
   int   m_cnt  = 0;
   bit   m_uf   = 1'b0;
   exp_t sb[$];

   always #5 clk_i = ~clk_i;

   bsg_counter_set_down_max_val_p128_init_val_p0 dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear_i),
      .set_i       (set_i),
      .val_i       (val_i),
      .down_i      (down_i),
      .count_o     (count_o),
      .zero_o      (zero_o),
      .underflow_o (underflow_o)
   );

   // Drive one cycle of inputs, push the reference result, then wait until 1 after the edge.
   task automatic step(input bit r, input bit c, input bit s, input int v, input bit d);
      int   base;
      bit   evt;
      exp_t e;
      reset_i = r; clear_i = c; set_i = s; val_i = 8'(v); down_i = d;
      if (r) begin
         m_cnt = INIT;
         m_uf  = 1'b0;
      end else begin
         base  = c ? 0 : (s ? ((v > MAX) ? MAX : v) : m_cnt);
         evt   = d && (base == 0);
         m_cnt = (d && base > 0) ? base - 1 : base;
         m_uf  = c ? evt : (m_uf | evt);
      end
      e.cnt  = 8'(m_cnt);
      e.zero = (m_cnt == 0);
      e.uf   = m_uf;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) step(1, 0, i[0], 50, ~i[0]);
         else       step(0, 0, 1, 3, 0);
         e = sb.pop_front();
         checks++;
         if (count_o !== e.cnt) begin
            errors++; $display("FAIL reset_count[%0d]: got %0d want %0d", i, count_o, e.cnt);
         end
         checks++;
         if (zero_o !== e.zero) begin
            errors++; $display("FAIL reset_zero[%0d]: got %b want %b", i, zero_o, e.zero);
         end
         checks++;
         if (underflow_o !== e.uf) begin
            errors++; $display("FAIL reset_uf[%0d]: got %b want %b", i, underflow_o, e.uf);
         end
      end
   endtask

   task automatic test_load_drain();
      exp_t e;
      int   want_c[7] = '{5, 4, 3, 2, 1, 0, 0};
      bit   want_u[7] = '{0, 0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 7; i++) begin
         if (i == 0) step(0, 0, 1, 5, 0);
         else        step(0, 0, 0, 0, 1);
         e = sb.pop_front();
         checks++;
         if (count_o !== e.cnt || e.cnt !== 8'(want_c[i])) begin
            errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count_o, want_c[i]);
         end
         checks++;
         if (zero_o !== e.zero || zero_o !== (want_c[i] == 0)) begin
            errors++; $display("FAIL drain_zero[%0d]: got %b want %b", i, zero_o, e.zero);
         end
         checks++;
         if (underflow_o !== e.uf || underflow_o !== want_u[i]) begin
            errors++; $display("FAIL drain_uf[%0d]: got %b want %b", i, underflow_o, want_u[i]);
         end
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      int   want_c[3] = '{128, 127, 0};
      bit   want_u[3] = '{1, 1, 1};
      step(1, 0, 0, 0, 0);
      void'(sb.pop_front());
      step(0, 0, 0, 0, 1);           // make underflow sticky first
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       step(0, 0, 1, 200, 0);
            1:       step(0, 0, 1, 200, 1);
            default: step(0, 0, 1, 0, 1);
         endcase
         e = sb.pop_front();
         checks++;
         if (count_o !== e.cnt || count_o !== 8'(want_c[i])) begin
            errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, count_o, want_c[i]);
         end
         checks++;
         if (underflow_o !== e.uf || underflow_o !== want_u[i]) begin
            errors++; $display("FAIL sat_uf[%0d]: got %b want %b", i, underflow_o, want_u[i]);
         end
      end
   endtask

   task automatic test_clear_priority();
      exp_t e;
      int   want_c[3] = '{40, 0, 0};
      bit   want_u[3] = '{1, 0, 1};
      step(0, 0, 1, 0, 1);
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       step(0, 0, 1, 40, 0);
            1:       step(0, 1, 1, 9, 0);
            default: step(0, 1, 0, 0, 1);
         endcase
         e = sb.pop_front();
         checks++;
         if (count_o !== e.cnt || count_o !== 8'(want_c[i])) begin
            errors++; $display("FAIL clr_count[%0d]: got %0d want %0d", i, count_o, want_c[i]);
         end
         checks++;
         if (underflow_o !== e.uf || underflow_o !== want_u[i]) begin
            errors++; $display("FAIL clr_uf[%0d]: got %b want %b", i, underflow_o, want_u[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      step(0, 0, 1, 100, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) void'(sb.pop_front());
      e = sb.pop_front();
      checks++;
      if (count_o !== e.cnt || count_o !== 8'd90) begin
         errors++; $display("FAIL mid_count_before: got %0d want 90", count_o);
      end
      step(1, 0, 1, 7, 0);
      e = sb.pop_front();
      checks++;
      if (count_o !== e.cnt || count_o !== 8'(INIT)) begin
         errors++; $display("FAIL mid_count_reset: got %0d want %0d", count_o, INIT);
      end
      checks++;
      if (underflow_o !== 1'b0 || zero_o !== 1'b1) begin
         errors++; $display("FAIL mid_flags_reset: got uf=%b zero=%b want uf=0 zero=1", underflow_o, zero_o);
      end
   endtask

   task automatic test_random();
      exp_t e;
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 255) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255)),
              $urandom_range(0, 1) == 1);
         e = sb.pop_front();
         checks++;
         if ({count_o, zero_o, underflow_o} !== {e.cnt, e.zero, e.uf}) begin
            errors++;
            $display("FAIL rand[%0d]: got cnt=%0d z=%b uf=%b want cnt=%0d z=%b uf=%b",
                     i, count_o, zero_o, underflow_o, e.cnt, e.zero, e.uf);
         end
      end
   endtask

   initial begin
      @(posedge clk_i);
      #1;
      test_reset();
      test_load_drain();
      test_saturation();
      test_clear_priority();
      test_reset_mid();
      test_random();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
